// File: rtl/keypad_code_entry.sv
// Keypad code entry front end for the passcode lock.
// Gathers digits, submits with an enter strobe and reports the result.
// Ports:
//   clk, reset (sync, active-high)
//   key_valid/key_code: scanner keystroke (0-9 digit, 0xC clear)
//   lock_status: lock response, 1 = open
//   passcode_out/entry_count: assembled code and digit count
//   enter: one-cycle submit strobe to the lock
//   granted/denied: one-cycle result pulses
//   locked_out/fail_count: lockout flag and consecutive failures
module keypad_code_entry #(
  parameter int DIGITS         = 4,
  parameter int DIGIT_W        = 4,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int MAX_FAILS      = 3,
  parameter int LOCKOUT_CYCLES = 5000
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              key_valid,
  input  logic [DIGIT_W-1:0]                key_code,
  input  logic                              lock_status,
  output logic [DIGITS*DIGIT_W-1:0]         passcode_out,
  output logic                              enter,
  output logic [$clog2(DIGITS+1)-1:0]       entry_count,
  output logic                              granted,
  output logic                              denied,
  output logic                              locked_out,
  output logic [$clog2(MAX_FAILS+1)-1:0]    fail_count
);

  localparam int PW   = DIGITS * DIGIT_W;
  localparam int CW   = $clog2(DIGITS + 1);
  localparam int FW   = $clog2(MAX_FAILS + 1);
  localparam int TMAX = (TIMEOUT_CYCLES > LOCKOUT_CYCLES) ?
                        TIMEOUT_CYCLES : LOCKOUT_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COLLECT,
    S_SETTLE,
    S_SUBMIT,
    S_WAIT,
    S_LOCKOUT
  } state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] pc_q, pc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [FW-1:0] fail_q, fail_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic          enter_q;
  logic          granted_q, granted_d;
  logic          denied_q, denied_d;
  logic          locked_q;

  logic          is_digit;
  logic          is_clear;
  logic [CW-1:0] cnt_inc;
  logic [PW-1:0] pc_shift;

  assign is_digit = key_valid && (key_code <= DIGIT_W'(9));
  assign is_clear = key_valid && (key_code == DIGIT_W'(12));
  assign cnt_inc  = cnt_q + CW'(1);
  assign pc_shift = {pc_q[PW-DIGIT_W-1:0], key_code};

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    cnt_d     = cnt_q;
    fail_d    = fail_q;
    tmr_d     = tmr_q;
    granted_d = 1'b0;
    denied_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (is_digit) begin
          pc_d    = PW'(key_code);
          cnt_d   = CW'(1);
          tmr_d   = TW'(TIMEOUT_CYCLES);
          state_d = S_COLLECT;
        end
      end
      S_COLLECT: begin
        // A key landing on the expiry cycle still counts.
        if (is_digit) begin
          pc_d  = pc_shift;
          cnt_d = cnt_inc;
          tmr_d = TW'(TIMEOUT_CYCLES);
          if (cnt_inc == CW'(DIGITS)) begin
            state_d = S_SETTLE;
          end
        end else if (is_clear || (tmr_q == '0)) begin
          pc_d    = '0;
          cnt_d   = '0;
          tmr_d   = '0;
          state_d = S_IDLE;
        end else begin
          tmr_d = tmr_q - TW'(1);
        end
      end
      S_SETTLE: begin
        // Lock registers the code a cycle before enter.
        state_d = S_SUBMIT;
      end
      S_SUBMIT: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = '0;
        if (lock_status) begin
          granted_d = 1'b1;
          fail_d    = '0;
          state_d   = S_IDLE;
        end else begin
          denied_d = 1'b1;
          if (fail_q >= FW'(MAX_FAILS - 1)) begin
            fail_d  = FW'(MAX_FAILS);
            tmr_d   = TW'(LOCKOUT_CYCLES);
            state_d = S_LOCKOUT;
          end else begin
            fail_d  = fail_q + FW'(1);
            state_d = S_IDLE;
          end
        end
      end
      S_LOCKOUT: begin
        // Leave on the edge where the timer hits 0.
        if (tmr_q <= TW'(1)) begin
          tmr_d   = '0;
          fail_d  = '0;
          state_d = S_IDLE;
        end else begin
          tmr_d = tmr_q - TW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      pc_q      <= '0;
      cnt_q     <= '0;
      fail_q    <= '0;
      tmr_q     <= '0;
      enter_q   <= 1'b0;
      granted_q <= 1'b0;
      denied_q  <= 1'b0;
      locked_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      cnt_q     <= cnt_d;
      fail_q    <= fail_d;
      tmr_q     <= tmr_d;
      enter_q   <= (state_d == S_SUBMIT);
      granted_q <= granted_d;
      denied_q  <= denied_d;
      locked_q  <= (state_d == S_LOCKOUT);
    end
  end

  assign passcode_out = pc_q;
  assign enter        = enter_q;
  assign entry_count  = cnt_q;
  assign granted      = granted_q;
  assign denied       = denied_q;
  assign locked_out   = locked_q;
  assign fail_count   = fail_q;

endmodule

// File: tb/tb_keypad_code_entry.sv
// Directed bench for keypad_code_entry.
// Short timeout and lockout keep the run brief.
module tb_keypad_code_entry;

  localparam int TO = 8;
  localparam int LO = 20;

  logic        clk = 1'b0;
  logic        reset;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        lock_status;
  logic [15:0] passcode_out;
  logic        enter;
  logic [2:0]  entry_count;
  logic        granted;
  logic        denied;
  logic        locked_out;
  logic [1:0]  fail_count;

  int n_chk = 0;
  int n_err = 0;

  keypad_code_entry #(
    .DIGITS(4),
    .DIGIT_W(4),
    .TIMEOUT_CYCLES(TO),
    .MAX_FAILS(3),
    .LOCKOUT_CYCLES(LO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .key_valid(key_valid),
    .key_code(key_code),
    .lock_status(lock_status),
    .passcode_out(passcode_out),
    .enter(enter),
    .entry_count(entry_count),
    .granted(granted),
    .denied(denied),
    .locked_out(locked_out),
    .fail_count(fail_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] k);
    key_valid = 1'b1;
    key_code  = k;
    step();
    key_valid = 1'b0;
    key_code  = 4'h0;
  endtask

  task automatic code4(input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] c, input logic [3:0] d);
    press(a);
    press(b);
    press(c);
    press(d);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_pc"}, 32'(passcode_out), 32'h0);
    chk({tag, "_cnt"}, 32'(entry_count), 32'h0);
    chk({tag, "_enter"}, 32'(enter), 32'h0);
    chk({tag, "_granted"}, 32'(granted), 32'h0);
    chk({tag, "_denied"}, 32'(denied), 32'h0);
    chk({tag, "_locked"}, 32'(locked_out), 32'h0);
    chk({tag, "_fail"}, 32'(fail_count), 32'h0);
  endtask

  initial begin
    #200000;
    $fatal(1, "FAIL watchdog expired");
  end

  initial begin
    int ne;
    int ng;
    int lk;
    reset       = 1'b1;
    key_valid   = 1'b0;
    key_code    = 4'h0;
    lock_status = 1'b0;
    step();
    step();
    chk_zero("rst");
    reset = 1'b0;

    // Keys 1,0,1,0 then open.
    press(4'h1);
    chk("t1_cnt1", 32'(entry_count), 32'd1);
    chk("t1_pc1", 32'(passcode_out), 32'h0001);
    press(4'h0);
    press(4'h1);
    press(4'h0);
    chk("t1_pc_c1", 32'(passcode_out), 32'h1010);
    chk("t1_cnt_c1", 32'(entry_count), 32'd4);
    chk("t1_enter_c1", 32'(enter), 32'h0);
    step();
    chk("t1_enter_c2", 32'(enter), 32'h1);
    chk("t1_pc_c2", 32'(passcode_out), 32'h1010);
    lock_status = 1'b1;
    step();
    chk("t1_enter_c3", 32'(enter), 32'h0);
    chk("t1_pc_c3", 32'(passcode_out), 32'h1010);
    chk("t1_gr_c3", 32'(granted), 32'h0);
    step();
    chk("t1_gr_c4", 32'(granted), 32'h1);
    chk("t1_fail_c4", 32'(fail_count), 32'h0);
    chk("t1_cnt_c4", 32'(entry_count), 32'h0);
    chk("t1_pc_c4", 32'(passcode_out), 32'h1010);
    lock_status = 1'b0;
    step();
    chk("t1_gr_c5", 32'(granted), 32'h0);

    // Clear mid-entry, then 3,4,5,6.
    press(4'h1);
    press(4'h2);
    chk("t2_pc12", 32'(passcode_out), 32'h0012);
    press(4'hC);
    chk("t2_pc_clr", 32'(passcode_out), 32'h0);
    chk("t2_cnt_clr", 32'(entry_count), 32'h0);
    code4(4'h3, 4'h4, 4'h5, 4'h6);
    chk("t2_pc", 32'(passcode_out), 32'h3456);
    lock_status = 1'b1;
    ne = 0;
    ng = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (enter) ne++;
      if (granted) ng++;
    end
    lock_status = 1'b0;
    chk("t2_enters", 32'(ne), 32'd1);
    chk("t2_grants", 32'(ng), 32'd1);

    // Timeout after 9 idle cycles discards entry.
    press(4'h7);
    for (int i = 0; i < TO + 1; i++) step();
    chk("t3_cnt_to", 32'(entry_count), 32'h0);
    chk("t3_pc_to", 32'(passcode_out), 32'h0);
    press(4'h8);
    chk("t3_pc8", 32'(passcode_out), 32'h0008);
    chk("t3_cnt8", 32'(entry_count), 32'd1);
    // Key exactly at expiry is kept.
    for (int i = 0; i < TO; i++) step();
    press(4'h9);
    chk("t3_pc89", 32'(passcode_out), 32'h0089);
    chk("t3_cnt89", 32'(entry_count), 32'd2);
    press(4'hA);
    chk("t3_ign_pc", 32'(passcode_out), 32'h0089);
    press(4'hC);
    chk("t3_clr_cnt", 32'(entry_count), 32'h0);

    // Three wrong codes then lockout.
    for (int f = 1; f <= 3; f++) begin
      code4(4'h9, 4'h9, 4'h9, 4'h9);
      step();
      step();
      step();
      chk("t4_denied", 32'(denied), 32'h1);
      chk("t4_fail", 32'(fail_count), 32'(f));
      chk("t4_locked", 32'(locked_out), (f == 3) ? 32'h1 : 32'h0);
    end
    lk = 0;
    ne = 0;
    for (int i = 0; i < 100; i++) begin
      if (!locked_out) break;
      lk++;
      if (enter) ne++;
      key_valid = 1'b1;
      key_code  = 4'(i % 10);
      step();
    end
    key_valid = 1'b0;
    chk("t4_lock_len", 32'(lk), 32'(LO));
    chk("t4_lock_enter", 32'(ne), 32'd0);
    chk("t4_fail_after", 32'(fail_count), 32'h0);
    chk("t4_cnt_after", 32'(entry_count), 32'h0);
    chk("t4_pc_after", 32'(passcode_out), 32'h9999);

    // Extra keys during settle/submit/wait are dropped.
    lock_status = 1'b1;
    code4(4'h1, 4'h2, 4'h3, 4'h4);
    press(4'h5);
    press(4'h6);
    press(4'h7);
    chk("t5_granted", 32'(granted), 32'h1);
    chk("t5_cnt", 32'(entry_count), 32'h0);
    chk("t5_pc", 32'(passcode_out), 32'h1234);
    step();
    chk("t5_cnt2", 32'(entry_count), 32'h0);
    lock_status = 1'b0;

    // Reset in COLLECT.
    press(4'h1);
    press(4'h2);
    chk("t6_cnt2", 32'(entry_count), 32'd2);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk_zero("t6_rst_col");

    // Reset in LOCKOUT.
    for (int f = 0; f < 3; f++) begin
      code4(4'h5, 4'h5, 4'h5, 4'h5);
      step();
      step();
      step();
    end
    step();
    step();
    step();
    chk("t6_locked", 32'(locked_out), 32'h1);
    chk("t6_fail3", 32'(fail_count), 32'd3);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk_zero("t6_rst_lo");

    // Fresh entry after reset.
    lock_status = 1'b1;
    code4(4'h4, 4'h3, 4'h2, 4'h1);
    step();
    chk("t6_enter", 32'(enter), 32'h1);
    step();
    step();
    chk("t6_granted", 32'(granted), 32'h1);
    chk("t6_pc", 32'(passcode_out), 32'h4321);
    lock_status = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
